// File: rtl/xiphos_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module      : xiphos_pkg                                                |
// | Description : Shared arbiter state encoding and source identifiers.     |
// | Revision    : 1.0                                                       |
// ---------------------------------------------------------------------------
package xiphos_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_X = 2'd1,
    OWN_Y = 2'd2
  } arb_state_t;

  localparam logic SRC_X = 1'b0;
  localparam logic SRC_Y = 1'b1;

endpackage
`default_nettype wire

// File: rtl/mux16_arbiter_mux16.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module      : MUX16                                                     |
// | Description : 2:1 word multiplexer, s = 0 selects X, s = 1 selects Y.   |
// | Revision    : 1.0                                                       |
// ---------------------------------------------------------------------------
module MUX16 #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic             s,
  output logic [WIDTH-1:0] Z
);

  assign Z = s ? Y : X;

endmodule
`default_nettype wire

// File: rtl/mux16_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module      : mux16_arbiter                                             |
// | Description : Round-robin arbiter with bounded lock, sharing one MUX16  |
// |               between sources X and Y into a one-entry output stage.    |
// | Revision    : 1.0                                                       |
// ---------------------------------------------------------------------------
module mux16_arbiter
  import xiphos_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             x_valid,
  input  logic             x_lock,
  input  logic [WIDTH-1:0] x_data,
  output logic             x_ready,
  input  logic             y_valid,
  input  logic             y_lock,
  input  logic [WIDTH-1:0] y_data,
  output logic             y_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_src,
  input  logic             out_ready,
  output logic             sel
);

  localparam int             CW          = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0]  c_max_burst = CW'(MAX_BURST);
  localparam logic [CW-1:0]  c_one       = CW'(1);

  arb_state_t       r_state;
  logic             r_ptr;
  logic [CW-1:0]    r_cnt;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_src;
  logic             r_sel;

  logic             w_slot_free;
  logic             w_has_win;
  logic             w_win;
  logic             w_sel;
  logic             w_win_owned;
  logic             w_win_lock;
  logic             w_owner_dropped;
  logic [CW-1:0]    w_cnt_next;
  logic [WIDTH-1:0] w_mux_data;

  // The owner keeps the path while it stays valid; otherwise plain round-robin.
  always_comb begin
    w_slot_free = !r_out_valid || out_ready;
    w_has_win   = 1'b0;
    w_win       = r_ptr;
    if (rst_n && w_slot_free) begin
      if (r_state == OWN_X && x_valid) begin
        w_has_win = 1'b1;
        w_win     = SRC_X;
      end else if (r_state == OWN_Y && y_valid) begin
        w_has_win = 1'b1;
        w_win     = SRC_Y;
      end else if (x_valid && y_valid) begin
        w_has_win = 1'b1;
        w_win     = r_ptr;
      end else if (x_valid) begin
        w_has_win = 1'b1;
        w_win     = SRC_X;
      end else if (y_valid) begin
        w_has_win = 1'b1;
        w_win     = SRC_Y;
      end
    end
  end

  assign x_ready = w_has_win && (w_win == SRC_X);
  assign y_ready = w_has_win && (w_win == SRC_Y);
  assign w_sel   = w_has_win ? w_win : r_sel;
  assign sel     = w_sel;

  assign w_win_owned     = (w_win == SRC_X) ? (r_state == OWN_X) : (r_state == OWN_Y);
  assign w_win_lock      = (w_win == SRC_X) ? x_lock : y_lock;
  assign w_cnt_next      = w_win_owned ? (r_cnt + c_one) : c_one;
  assign w_owner_dropped = (r_state == OWN_X && !x_valid) || (r_state == OWN_Y && !y_valid);

  MUX16 #(
    .WIDTH (WIDTH)
  ) u_mux16 (
    .X (x_data),
    .Y (y_data),
    .s (w_sel),
    .Z (w_mux_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_ptr       <= SRC_X;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_src   <= SRC_X;
      r_sel       <= SRC_X;
    end else begin
      r_sel <= w_sel;
      if (w_has_win) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_mux_data;
        r_out_src   <= w_win;
        if (w_win_lock && (w_cnt_next < c_max_burst)) begin
          r_state <= (w_win == SRC_X) ? OWN_X : OWN_Y;
          r_cnt   <= w_cnt_next;
        end else begin
          r_state <= IDLE;
          r_cnt   <= '0;
          r_ptr   <= ~w_win;
        end
      end else begin
        // An owner that goes quiet gives up its lock and its priority.
        if (w_slot_free && w_owner_dropped) begin
          r_state <= IDLE;
          r_cnt   <= '0;
          r_ptr   <= (r_state == OWN_X) ? SRC_Y : SRC_X;
        end
        if (r_out_valid && out_ready) begin
          r_out_valid <= 1'b0;
        end
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_src   = r_out_src;

endmodule
`default_nettype wire
